// File: rtl/ex_case_pkg.sv
// ex_case_pkg: shared encodings for the ex_case byte stream.
// Holds state encoding, default header byte, byte width and checksum.
package ex_case_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_DEF = 8'h55;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_ST  = 3'd1,
    PAY     = 3'd2,
    CSUM_ST = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Running checksum: payload sum mod 256, carry discarded.
  function automatic logic [BYTE_W-1:0] csum_add(
    input logic [BYTE_W-1:0] s,
    input logic [BYTE_W-1:0] b
  );
    return s + b;
  endfunction

endpackage

// File: rtl/ex_case_rx_buf.sv
// ex_case_rx_buf: DEPTH x BYTE_W payload store.
// Ports: clk, we/waddr/wdata sync write, raddr -> rdata async read.
module ex_case_rx_buf
  import ex_case_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ex_case_rx.sv
// ex_case_rx: frames HDR/LEN/payload/CSUM bytes, replays good payloads.
// Ports: sclk, rst, i_dv/i_data in, i_rdy, o_dv/o_data/o_last/o_len, pulses.
module ex_case_rx
  import ex_case_pkg::*;
#(
  parameter logic [7:0] HDR     = HDR_DEF,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 16,
  localparam int        LW      = $clog2(MAX_LEN + 1),
  localparam int        AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          i_dv,
  input  logic [7:0]    i_data,
  input  logic          i_rdy,
  output logic          o_dv,
  output logic [7:0]    o_data,
  output logic          o_last,
  output logic [LW-1:0] o_len,
  output logic          o_frame_ok,
  output logic          o_frame_err,
  output logic          o_drop
);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wr_q, wr_d;
  logic [LW-1:0]   rd_q, rd_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic            we;
  logic [7:0]      rdata;
  logic            last;

  ex_case_rx_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (sclk),
    .we    (we),
    .waddr (wr_q[AW-1:0]),
    .wdata (i_data),
    .raddr (rd_q[AW-1:0]),
    .rdata (rdata)
  );

  assign last = (rd_q == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    idle_d  = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_dv && i_data == HDR) state_d = LEN_ST;
      end
      LEN_ST: begin
        if (i_dv) begin
          if (i_data == 8'd0 || 32'(i_data) > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = i_data[LW-1:0];
            wr_d    = '0;
            sum_d   = '0;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (i_dv) begin
          we    = 1'b1;
          wr_d  = wr_q + LW'(1);
          sum_d = csum_add(sum_q, i_data);
          if (wr_q == len_q - LW'(1)) state_d = CSUM_ST;
        end
      end
      CSUM_ST: begin
        if (i_dv) begin
          if (i_data == sum_q) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        drop_d = i_dv;
        if (i_rdy) begin
          rd_d = rd_q + LW'(1);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Idle-gap watchdog while a frame is being received.
    if (!i_dv &&
        (state_q == LEN_ST || state_q == PAY || state_q == CSUM_ST)) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign o_dv        = (state_q == DRAIN);
  assign o_data      = o_dv ? rdata : 8'd0;
  assign o_last      = o_dv && last;
  assign o_len       = o_dv ? len_q : '0;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_ex_case_rx.sv
// tb_ex_case_rx: scoreboard bench for ex_case_rx.
// Stimulus pushes expected pulses/bytes; a negedge monitor pops and compares.
module tb_ex_case_rx;

  localparam int LW = 5;
  localparam int EV_OK = 1, EV_ERR = 2, EV_DROP = 3;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          i_dv = 1'b0;
  logic [7:0]    i_data = 8'd0;
  logic          i_rdy = 1'b1;
  logic          o_dv, o_last, o_frame_ok, o_frame_err, o_drop;
  logic [7:0]    o_data;
  logic [LW-1:0] o_len;

  ex_case_rx dut (
    .sclk(sclk), .rst(rst), .i_dv(i_dv), .i_data(i_data), .i_rdy(i_rdy),
    .o_dv(o_dv), .o_data(o_data), .o_last(o_last), .o_len(o_len),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err), .o_drop(o_drop)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [LW-1:0] n;
  } obyte_t;

  obyte_t     qb[$];
  int         qe[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         passes = 0;
  logic       hold_v = 1'b0;
  obyte_t     hold;
  obyte_t     cur;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic pop_evt(input int code, input string nm);
    if (qe.size() == 0) begin
      checks++;
      $display("FAIL %s: got unexpected pulse expected none", nm);
    end else begin
      chk(nm, code, qe.pop_front());
    end
  endtask

  always @(negedge sclk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      cur = '{d: o_data, l: o_last, n: o_len};
      if (o_frame_ok || o_frame_err || o_drop)
        chk("pulse_excl",
            int'(o_frame_ok) + int'(o_frame_err) + int'(o_drop), 1);
      if (o_frame_ok)  pop_evt(EV_OK, "frame_ok");
      if (o_frame_err) pop_evt(EV_ERR, "frame_err");
      if (o_drop)      pop_evt(EV_DROP, "drop");
      if (hold_v) begin
        chk("dv_held", int'(o_dv), 1);
        if (o_dv) chk("out_stable", int'(cur), int'(hold));
      end
      if (o_dv && i_rdy) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL out_byte: got %0h unexpected expected none", cur);
        end else begin
          chk("out_byte", int'(cur), int'(qb.pop_front()));
        end
      end
      hold_v = o_dv && !i_rdy;
      hold   = cur;
    end
  end

  task automatic cyc(input logic dv, input logic [7:0] d);
    i_dv   = dv;
    i_data = d;
    @(posedge sclk);
    #1;
  endtask

  task automatic send();
    foreach (stim[i]) cyc(1'b1, stim[i]);
    i_dv = 1'b0;
  endtask

  task automatic exp_b(input logic [7:0] d, input logic l, input int n);
    qb.push_back('{d: d, l: l, n: LW'(n)});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_dv && n < 100) begin
      cyc(1'b0, 8'd0);
      n++;
    end
    chk("drain_done", int'(o_dv), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dv"}, int'(o_dv), 0);
    chk({nm, "_data"}, int'(o_data), 0);
    chk({nm, "_last"}, int'(o_last), 0);
    chk({nm, "_len"}, int'(o_len), 0);
    chk({nm, "_ok"}, int'(o_frame_ok), 0);
    chk({nm, "_err"}, int'(o_frame_err), 0);
    chk({nm, "_drop"}, int'(o_drop), 0);
  endtask

  initial begin
    logic bp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] gap [5] = '{8'h55, 8'h02, 8'hAA, 8'h10, 8'hBA};

    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk_zero("reset");
    rst = 1'b0;

    // Good frame, contiguous.
    qe.push_back(EV_OK);
    exp_b(8'h10, 0, 3); exp_b(8'h20, 0, 3); exp_b(8'h30, 1, 3);
    stim = '{8'h55, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    send();
    chk("ok_latency", int'(o_frame_ok), 1);
    chk("dv_with_ok", int'(o_dv), 1);
    wait_idle();

    // Checksum wraps mod 256.
    qe.push_back(EV_OK);
    exp_b(8'hFF, 0, 2); exp_b(8'h02, 1, 2);
    stim = '{8'h55, 8'h02, 8'hFF, 8'h02, 8'h01};
    send();
    wait_idle();

    // Bad checksum.
    qe.push_back(EV_ERR);
    stim = '{8'h55, 8'h02, 8'h01, 8'h02, 8'h04};
    send();
    chk("badsum_err", int'(o_frame_err), 1);
    cyc(1'b0, 8'd0);
    chk("badsum_no_dv", int'(o_dv), 0);

    // Length bounds.
    qe.push_back(EV_ERR);
    stim = '{8'h55, 8'h00};
    send();
    chk("len0_err", int'(o_frame_err), 1);
    qe.push_back(EV_ERR);
    stim = '{8'h55, 8'h11};
    send();
    chk("len17_err", int'(o_frame_err), 1);
    qe.push_back(EV_OK);
    stim = '{8'h55, 8'h10};
    for (int i = 0; i < 16; i++) begin
      stim.push_back(8'h01);
      exp_b(8'h01, i == 15, 16);
    end
    stim.push_back(8'h10);
    send();
    chk("len16_ok", int'(o_frame_ok), 1);
    wait_idle();

    // Timeout after 16 idle cycles.
    qe.push_back(EV_ERR);
    stim = '{8'h55, 8'h02, 8'hAA};
    send();
    repeat (15) cyc(1'b0, 8'd0);
    chk("to_not_yet", int'(o_frame_err), 0);
    cyc(1'b0, 8'd0);
    chk("to_at_16", int'(o_frame_err), 1);

    // 15-cycle gaps are tolerated.
    qe.push_back(EV_OK);
    exp_b(8'hAA, 0, 2); exp_b(8'h10, 1, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, gap[i]);
      if (i < 4) repeat (15) cyc(1'b0, 8'd0);
    end
    i_dv = 1'b0;
    chk("gap15_ok", int'(o_frame_ok), 1);
    wait_idle();

    // Back-pressure.
    qe.push_back(EV_OK);
    exp_b(8'hA1, 0, 3); exp_b(8'hB2, 0, 3); exp_b(8'hC3, 1, 3);
    stim = '{8'h55, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    send();
    for (int k = 0; k < 6; k++) begin
      i_rdy = bp[k];
      cyc(1'b0, 8'd0);
    end
    chk("bp_done", int'(o_dv), 0);
    i_rdy = 1'b1;

    // Drops during a stalled drain.
    i_rdy = 1'b0;
    qe.push_back(EV_OK);
    stim = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send();
    repeat (4) qe.push_back(EV_DROP);
    stim = '{8'h55, 8'h01, 8'h07, 8'h07};
    send();
    cyc(1'b0, 8'd0);
    chk("drop_dv_held", int'(o_dv), 1);
    exp_b(8'h11, 0, 3); exp_b(8'h22, 0, 3); exp_b(8'h33, 1, 3);
    i_rdy = 1'b1;
    wait_idle();
    repeat (3) cyc(1'b0, 8'd0);

    // Reset mid-payload.
    stim = '{8'h55, 8'h04, 8'h01, 8'h02};
    send();
    rst = 1'b1;
    cyc(1'b0, 8'd0);
    chk_zero("midrst");
    rst = 1'b0;
    qe.push_back(EV_OK);
    exp_b(8'h09, 1, 1);
    stim = '{8'h55, 8'h01, 8'h09, 8'h09};
    send();
    chk("post_rst_ok", int'(o_frame_ok), 1);
    wait_idle();

    repeat (4) cyc(1'b0, 8'd0);
    chk("evt_q_empty", qe.size(), 0);
    chk("byte_q_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_case_rx.md
Name: ex_case_rx

Overview:
Receiving end of the ex_case byte stream (o_dv/o_data source). It frames the incoming valid-qualified bytes as header, length, payload and checksum, then buffers the payload. Frames that pass the checksum are replayed on a ready/valid output; bad or stalled frames are flagged and dropped. It sits directly downstream of ex_case in the ex_case system bench and top level.

Parameters:
HDR, 8'h55, frame start byte.
MAX_LEN, 16, maximum payload bytes; legal range 1..255.
TIMEOUT, 16, maximum consecutive idle cycles (i_dv=0) allowed inside a frame.

Ports:
sclk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
i_dv  in  1  input byte valid, one byte per cycle when high.
i_data  in  8  input byte, sampled when i_dv=1.
i_rdy  in  1  downstream ready for output payload.
o_dv  out  1  output payload byte valid.
o_data  out  8  output payload byte.
o_last  out  1  high with the final payload byte of a frame.
o_len  out  clog2(MAX_LEN+1)  length of the frame being drained; valid while o_dv=1.
o_frame_ok  out  1  one-cycle pulse: checksum matched.
o_frame_err  out  1  one-cycle pulse: bad length, bad checksum or timeout.
o_drop  out  1  one-cycle pulse: input byte discarded during drain.

Behaviour:
- Reset values: state IDLE; all outputs 0; pointers, length, sum and idle counter 0. Buffer contents are don't-care. Reset wins over every other event, including mid-frame and mid-drain.
- Frame format: HDR, LEN, LEN payload bytes, CSUM. CSUM = sum of payload bytes mod 256, wrapping with no carry out.
- FSM, evaluated on cycles with i_dv=1 unless stated otherwise:
  IDLE: i_data==HDR -> LEN_ST. Any other byte is ignored silently.
  LEN_ST: LEN==0 or LEN>MAX_LEN -> o_frame_err pulse, back to IDLE. Otherwise latch LEN, clear wr_ptr and sum, -> PAY.
  PAY: write byte to buf[wr_ptr], increment wr_ptr, add byte to sum. When the LEN-th byte is written -> CSUM_ST. A byte equal to HDR is treated as data, with no resync.
  CSUM_ST: byte==sum -> o_frame_ok pulse, clear rd_ptr, -> DRAIN. Otherwise o_frame_err pulse, back to IDLE.
  DRAIN: o_dv=1 and o_data=buf[rd_ptr]. On o_dv&i_rdy, increment rd_ptr. o_last=1 when rd_ptr==LEN-1. Accepting the last byte returns to IDLE. Any i_dv=1 in DRAIN gives an o_drop pulse and discards the byte, including a byte equal to HDR.
- Timeout: in LEN_ST, PAY and CSUM_ST, the idle counter increments on each i_dv=0 cycle and clears on each i_dv=1 cycle. When it reaches TIMEOUT, pulse o_frame_err, go to IDLE and clear the counter. In IDLE and DRAIN the counter is held at 0.
- Latency: o_frame_ok/o_frame_err are registered and assert the cycle after the deciding byte is sampled. o_dv rises in the same cycle as o_frame_ok.
- Output handshake: while o_dv=1 and i_rdy=0, o_data, o_last and o_len hold stable. o_dv never deasserts until the last byte is accepted. Peak throughput is one byte per cycle with i_rdy held high.
- The last byte of a frame and the first byte of the next cannot overlap. Bytes arriving in the cycle DRAIN exits are processed in IDLE on the next cycle.
- o_frame_ok, o_frame_err and o_drop are mutually exclusive within any cycle.

Decomposition:
- Shared package/include ex_case_pkg holds:
  - state encoding IDLE/LEN_ST/PAY/CSUM_ST/DRAIN, 3-bit;
  - HDR default 8'h55;
  - byte width 8;
  - the checksum definition, shared with the ex_case source and the bench model.
- One sub-module, ex_case_rx_buf: MAX_LEN x 8 register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr -> rdata). The FSM, counters and outputs stay in ex_case_rx.

Test Plan:
- Good frame: 55 03 10 20 30 60, contiguous, i_rdy=1 -> o_frame_ok pulse one cycle after 60; o_dv for 3 cycles with o_data 10,20,30; o_last only with 30; o_len=3.
- Checksum wrap, then bad checksum: 55 02 FF 02 01 -> ok, outputs FF,02. Then 55 02 01 02 04 -> o_frame_err pulse, o_dv stays 0.
- Length bounds: 55 00 -> err; 55 11 (17) -> err; 55 10 + 16 bytes of 01 + 10 -> ok, 16 bytes out, o_last on the 16th.
- Timeout: 55 02 AA then i_dv=0 -> o_frame_err exactly at the 16th idle cycle. A repeat run with gaps of 15 idle cycles between bytes completes ok.
- Back-pressure and drop: good 3-byte frame with i_rdy toggling 1,0,0,1,0,1 -> each byte held stable until accepted, no loss. Feeding 55 01 07 07 during drain -> four o_drop pulses, no new frame.
- Reset mid-PAY: assert rst after 55 04 01 02 -> all outputs 0 next cycle. Frame 55 01 09 09 then succeeds, output 09.
